// File: rtl/right_shift_seq_32b_pkg.sv
// Shared types and constants for the sequential 32-bit right shifter.
// Mode and state encodings live here so the top and the stage agree.
package right_shift_seq_32b_pkg;

  localparam int STAGES = 5;

  typedef enum logic [1:0] {
    SHR  = 2'b00,
    SHRA = 2'b01,
    ROR  = 2'b10,
    RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/right_shift_seq_32b_stage.sv
// One conditional right shift by 2^stage_k with mode-dependent fill.
// The reserved mode falls through to logical behaviour.
module right_shift_stage
  import right_shift_seq_32b_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [2:0]  stage_k,
  input  logic        en,
  input  mode_e       mode,
  input  logic        fill_bit,
  output logic [31:0] data_out
);

  logic [4:0]  amt;
  logic [63:0] ext;

  always_comb begin
    amt = 5'b00001 << stage_k;
    ext = {32'h0, data_in};
    case (mode)
      SHRA:    ext = {{32{fill_bit}}, data_in};
      ROR:     ext = {data_in, data_in};
      default: ext = {32'h0, data_in};
    endcase
    data_out = en ? 32'(ext >> amt) : data_in;
  end

endmodule

// File: rtl/right_shift_seq_32b.sv
// Sequential barrel right shifter: one log-stage per cycle, fixed six-cycle
// start-to-done latency, registered busy/done/out.
module right_shift_seq_32b
  import right_shift_seq_32b_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [31:0] shift,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        oob_q, oob_d;
  mode_e       mode_q, mode_d;
  logic        sign_q, sign_d;
  logic [31:0] out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] stage_out;

  right_shift_stage u_stage (
    .data_in  (work_q),
    .stage_k  (cnt_q),
    .en       (shamt_q[cnt_q]),
    .mode     (mode_q),
    .fill_bit (sign_q),
    .data_out (stage_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    oob_d   = oob_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    out_d   = out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          work_d  = in;
          shamt_d = shift[4:0];
          oob_d   = |shift[31:5];
          mode_d  = mode_e'(mode);
          sign_d  = in[31];
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'(STAGES - 1)) begin
          state_d = DONE;
          // Oversized amounts saturate to the fill value; rotate ignores them.
          if (oob_q && mode_q != ROR)
            out_d = (mode_q == SHRA) ? {32{sign_q}} : 32'h0;
          else
            out_d = stage_out;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      work_q  <= 32'h0;
      shamt_q <= 5'd0;
      oob_q   <= 1'b0;
      mode_q  <= SHR;
      sign_q  <= 1'b0;
      out_q   <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      oob_q   <= oob_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
